weight_fifo_array: RTL and testbench

Parametrised N-column weight staging buffer that feeds the systolic MMU weight-load path. One shared narrow write bus fills any subset of per-column circular FIFOs. A single common pop drains all columns in lockstep. Column k output passes through a k-stage skew chain, so weights enter the array as a diagonal wavefront. Adds full/empty/count status, overflow/underflow protection and sticky error flags.

---
 rtl/weight_fifo_array.sv | 111 +++++++++++
 tb/tb_weight_fifo_array.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_fifo_array.sv
// Weight staging buffer: one circular FIFO per column, filled from a shared write bus and
// drained by a common pop. Column k output is delayed through a k-stage skew chain.
module weight_fifo_array #(
    parameter int DATA_W   = 8,
    parameter int NUM_COLS = 2,
    parameter int DEPTH    = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_COLS-1:0]        push_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       pop,
    output logic [NUM_COLS*DATA_W-1:0] col_out,
    output logic [NUM_COLS-1:0]        col_valid,
    output logic [NUM_COLS*DATA_W-1:0] col_raw,
    output logic [NUM_COLS-1:0]        full,
    output logic [NUM_COLS-1:0]        empty,
    output logic [NUM_COLS*CNT_W-1:0]  count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [NUM_COLS-1:0] push_drop;

    for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  cnt;
        logic [DATA_W-1:0] raw;
        logic              push_ok;
        logic              pop_ok;

        assign full[k]   = (cnt == CNT_W'(DEPTH));
        assign empty[k]  = (cnt == '0);
        // A full column can still take a push when the same-cycle pop frees a slot.
        assign push_ok   = push_en[k] && (!full[k] || (pop && !empty[k]));
        assign pop_ok    = pop && !empty[k];
        assign push_drop[k] = push_en[k] && !push_ok;
        assign raw       = empty[k] ? '0 : mem[rd_ptr];

        assign col_raw[k*DATA_W +: DATA_W] = raw;
        assign count[k*CNT_W +: CNT_W]     = cnt;

        always_ff @(posedge clk) begin
            if (push_ok)
                mem[wr_ptr] <= data_in;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push_ok, pop_ok})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
        end

        if (k == 0) begin : g_noskew
            assign col_out[DATA_W-1:0] = raw;
            assign col_valid[0]        = !empty[0];
        end else begin : g_skew
            logic [DATA_W-1:0] sk_data [k];
            logic [k-1:0]      sk_valid;

            // Skew stages only advance on pop so the wavefront stays aligned with the drain.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < k; j++)
                        sk_data[j] <= '0;
                    sk_valid <= '0;
                end else if (pop) begin
                    sk_data[0]  <= raw;
                    sk_valid[0] <= !empty[k];
                    for (int j = 1; j < k; j++) begin
                        sk_data[j]  <= sk_data[j-1];
                        sk_valid[j] <= sk_valid[j-1];
                    end
                end
            end

            assign col_out[k*DATA_W +: DATA_W] = sk_data[k-1];
            assign col_valid[k]                = sk_valid[k-1];
        end
    end

    // Error flags are sticky; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (|push_drop) | (overflow & ~clear_err);
            underflow <= (pop & (|empty)) | (underflow & ~clear_err);
        end
    end

endmodule

// File: tb/tb_weight_fifo_array.sv
// Directed bench for weight_fifo_array: a 2-column instance for FIFO/flag behaviour and a
// 4-column instance for the diagonal skew wavefront.
module tb_weight_fifo_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, pop, pop4, clear_err;
    logic [1:0]  push_en;
    logic [3:0]  push_en4;
    logic [7:0]  data_in;

    logic [15:0] col_out, col_raw;
    logic [1:0]  col_valid, full, empty;
    logic [5:0]  count;
    logic        overflow, underflow;

    logic [31:0] col_out4, col_raw4;
    logic [3:0]  col_valid4, full4, empty4;
    logic [11:0] count4;
    logic        overflow4, underflow4;

    int checks = 0;
    int errors = 0;

    weight_fifo_array #(.DATA_W(8), .NUM_COLS(2), .DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .push_en(push_en), .data_in(data_in), .pop(pop),
        .col_out(col_out), .col_valid(col_valid), .col_raw(col_raw), .full(full),
        .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
        .clear_err(clear_err)
    );

    weight_fifo_array #(.DATA_W(8), .NUM_COLS(4), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .push_en(push_en4), .data_in(data_in), .pop(pop4),
        .col_out(col_out4), .col_valid(col_valid4), .col_raw(col_raw4), .full(full4),
        .empty(empty4), .count(count4), .overflow(overflow4), .underflow(underflow4),
        .clear_err(clear_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [1:0] m, input logic [7:0] d);
        push_en = m;
        data_in = d;
        tick();
        push_en = '0;
    endtask

    logic [7:0]  exp_seq [4];
    logic [31:0] eo;
    logic [3:0]  ev;
    int          idx;

    initial begin
        reset = 1'b1; pop = 1'b0; pop4 = 1'b0; clear_err = 1'b0;
        push_en = '0; push_en4 = '0; data_in = '0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();

        // reset state
        chk("rst_empty", empty, 2'b11);
        chk("rst_full", full, 2'b00);
        chk("rst_count", count, 6'd0);
        chk("rst_col_out", col_out, 16'h0000);
        chk("rst_col_valid", col_valid, 2'b00);
        chk("rst_col_raw", col_raw, 16'h0000);
        chk("rst_flags", {overflow, underflow}, 2'b00);

        // basic fill and drain with one-cycle skew on column 1
        push2(2'b01, 8'h11);
        push2(2'b01, 8'h22);
        push2(2'b10, 8'hA1);
        push2(2'b10, 8'hA2);
        chk("fill_count", count, {3'd2, 3'd2});
        chk("fill_raw", col_raw, 16'hA111);
        chk("fill_out", col_out, 16'h0011);
        chk("fill_valid", col_valid, 2'b01);
        pop = 1'b1;
        tick();
        chk("pop1_out", col_out, 16'hA122);
        chk("pop1_valid", col_valid, 2'b11);
        tick();
        pop = 1'b0;
        chk("pop2_out", col_out, 16'hA200);
        chk("pop2_valid", col_valid, 2'b10);
        chk("pop2_empty", empty, 2'b11);
        chk("pop2_underflow", underflow, 1'b0);

        // overflow, then push-with-pop on a full column across the pointer wrap
        push2(2'b01, 8'h01);
        push2(2'b01, 8'h02);
        push2(2'b01, 8'h03);
        push2(2'b01, 8'h04);
        chk("full_flag", full, 2'b01);
        chk("full_count", count, {3'd0, 3'd4});
        push2(2'b01, 8'h55);
        chk("ovf_count", count, {3'd0, 3'd4});
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_raw", col_raw[7:0], 8'h01);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("ovf_clear", overflow, 1'b0);
        pop = 1'b1;
        push2(2'b01, 8'h55);
        pop = 1'b0;
        chk("pp_count", count, {3'd0, 3'd4});
        chk("pp_overflow", overflow, 1'b0);
        chk("pp_underflow", underflow, 1'b1);
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_order%0d", i), col_raw[7:0], exp_seq[i]);
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        chk("wrap_empty", empty, 2'b11);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("unf_clear1", underflow, 1'b0);

        // pop with column 1 empty: column 1 pointer must stay put
        push2(2'b01, 8'h33);
        chk("unf_raw_pre", col_raw, 16'h0033);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("unf_empty", empty, 2'b11);
        chk("unf_out", col_out, 16'h0000);
        chk("unf_valid", col_valid, 2'b00);
        chk("unf_flag", underflow, 1'b1);
        push2(2'b10, 8'h77);
        chk("frozen_raw", col_raw, 16'h7700);
        chk("frozen_count", count, {3'd1, 3'd0});
        clear_err = 1'b1;
        tick();
        chk("unf_clear2", underflow, 1'b0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        clear_err = 1'b0;
        chk("set_wins", underflow, 1'b1);
        chk("sw_out", col_out, 16'h7700);
        chk("sw_valid", col_valid, 2'b10);

        // reset with entries queued and skew data pending
        push2(2'b01, 8'h44);
        push2(2'b01, 8'h45);
        chk("pend_out", col_out, 16'h7744);
        chk("pend_valid", col_valid, 2'b11);
        chk("pend_count", count, {3'd0, 3'd2});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_count", count, 6'd0);
        chk("mrst_empty", empty, 2'b11);
        chk("mrst_valid", col_valid, 2'b00);
        chk("mrst_out", col_out, 16'h0000);
        chk("mrst_raw", col_raw, 16'h0000);
        chk("mrst_flags", {overflow, underflow}, 2'b00);

        // 4-column diagonal wavefront
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                push_en4 = 4'(1 << k);
                data_in  = 8'(k * 16 + i);
                tick();
            end
        end
        push_en4 = '0;
        chk("c4_count", count4, 12'h924);
        chk("c4_full", full4, 4'hF);
        chk("c4_raw", col_raw4, 32'h30201000);
        chk("c4_overflow", overflow4, 1'b0);
        for (int t = 0; t < 8; t++) begin
            eo = '0;
            ev = '0;
            for (int k = 0; k < 4; k++) begin
                idx = t - k;
                if (idx >= 0 && idx <= 3) begin
                    ev[k] = 1'b1;
                    eo[k*8 +: 8] = 8'(k * 16 + idx);
                end
            end
            chk($sformatf("diag_out_t%0d", t), col_out4, eo);
            chk($sformatf("diag_valid_t%0d", t), col_valid4, ev);
            pop4 = 1'b1;
            tick();
        end
        pop4 = 1'b0;
        chk("c4_empty", empty4, 4'hF);
        chk("c4_underflow", underflow4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
